// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/op widths, op-class encodings and flag bit positions.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 6;

  localparam logic [2:0] CLS_ADD = 3'b000;
  localparam logic [2:0] CLS_MUL = 3'b001;
  localparam logic [2:0] CLS_SHF = 3'b010;
  localparam logic [2:0] CLS_LOG = 3'b011;
  localparam logic [2:0] CLS_CMP = 3'b100;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/C/V derivation from an ALU op and its result.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  // Only the class field and the signed-multiply bit influence the flags.
  logic unusedOpBits;
  assign unusedOpBits = ^op[2:1];

  always_comb begin
    flags = 4'b0000;
    case (op[5:3])
      CLS_ADD: begin
        flags[FLG_Z] = (result[7:0] == 8'h00);
        flags[FLG_N] = result[7];
        flags[FLG_C] = result[8];
        flags[FLG_V] = result[9];
      end
      CLS_MUL: begin
        flags[FLG_Z] = (result == '0);
        flags[FLG_N] = op[0] & result[15];
      end
      CLS_SHF, CLS_LOG: begin
        flags[FLG_Z] = (result[7:0] == 8'h00);
        flags[FLG_N] = result[7];
      end
      CLS_CMP: begin
        flags[FLG_Z] = ~result[0];
      end
      default: flags = 4'b0000;
    endcase
  end

endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO capturing ALU results with their op and derived flags.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [OP_W-1:0]          in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [OP_W-1:0]          out_op,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] resultMem [DEPTH];
  logic [OP_W-1:0]   opMem     [DEPTH];
  logic [3:0]        flagMem   [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [3:0]       inFlags;
  logic             doPush;
  logic             doPop;

  alu_flag_gen uFlagGen (
    .op     (in_op),
    .result (in_result),
    .flags  (inFlags)
  );

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign doPush    = in_valid & in_ready;
  assign doPop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && doPush) begin
      resultMem[wrPtr] <= in_result;
      opMem[wrPtr]     <= in_op;
      flagMem[wrPtr]   <= inFlags;
    end
  end

  assign out_result = out_valid ? resultMem[rdPtr] : '0;
  assign out_op     = out_valid ? opMem[rdPtr]     : '0;
  assign out_flags  = out_valid ? flagMem[rdPtr]   : '0;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo with a queue-based reference model.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [5:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [5:0]  out_op;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  int passCnt  = 0;
  int totalCnt = 0;

  logic [25:0] modelQ [$];
  int          modelDrop = 0;
  logic [15:0] popped [$];

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_flags  (out_flags),
    .count      (count),
    .drop_cnt   (drop_cnt)
  );

  function automatic logic [3:0] modelFlags(input logic [5:0] op, input logic [15:0] res);
    logic z, n, c, v;
    z = 0; n = 0; c = 0; v = 0;
    if (op[5:3] == 3'd0) begin
      z = (res % 256) == 0; n = res[7]; c = res[8]; v = res[9];
    end else if (op[5:3] == 3'd1) begin
      z = (res == 0); n = op[0] && res[15];
    end else if (op[5:3] == 3'd2 || op[5:3] == 3'd3) begin
      z = (res % 256) == 0; n = res[7];
    end else if (op[5:3] == 3'd4) begin
      z = (res % 2) == 0;
    end
    return {z, n, c, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compareAll();
    logic [25:0] head;
    int occ;
    occ  = modelQ.size();
    head = (occ != 0) ? modelQ[0] : 26'd0;
    check("out_valid", 32'(out_valid), 32'(occ != 0));
    check("in_ready", 32'(in_ready), 32'(occ < DEPTH));
    check("count", 32'(count), 32'(occ));
    check("drop_cnt", 32'(drop_cnt), 32'(modelDrop));
    check("out_result", 32'(out_result), 32'(head[25:10]));
    check("out_op", 32'(out_op), 32'(head[9:4]));
    check("out_flags", 32'(out_flags), 32'(head[3:0]));
  endtask

  // Predict the post-edge state from current inputs, clock once, then compare.
  task automatic step();
    int occ;
    bit willPush, willPop;
    occ = modelQ.size();
    if (rst) begin
      modelQ.delete();
      modelDrop = 0;
    end else begin
      willPush = in_valid && (occ < DEPTH);
      willPop  = out_ready && (occ > 0);
      if (in_valid && !(occ < DEPTH) && modelDrop < 255) modelDrop++;
      if (out_valid && out_ready) popped.push_back(out_result);
      if (willPop) void'(modelQ.pop_front());
      if (willPush) modelQ.push_back({in_result, in_op, modelFlags(in_op, in_result)});
    end
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic drive(input bit v, input logic [15:0] res, input logic [5:0] op, input bit rdy);
    in_valid = v; in_result = res; in_op = op; out_ready = rdy;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 16'h0, 6'h0, 0);
    step();
    step();
    rst = 1'b0;
    step();
    check("reset_count_lit", 32'(count), 32'd0);
    check("reset_in_ready_lit", 32'(in_ready), 32'd1);

    // push into empty with out_ready=1: no same-cycle pop
    drive(1, 16'h0100, 6'b000000, 1);
    step();
    check("add_result_lit", 32'(out_result), 32'h0100);
    check("add_flags_lit", 32'(out_flags), 32'b1010);
    check("add_count_lit", 32'(count), 32'd1);
    drive(0, 16'h0, 6'h0, 1);
    step();

    // fill, then overflow attempts
    for (int i = 1; i <= 4; i++) begin
      drive(1, 16'(i), 6'b011000, 0);
      step();
    end
    check("full_count_lit", 32'(count), 32'd4);
    check("full_ready_lit", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h0005, 6'b011000, 0);
      step();
    end
    check("drop3_lit", 32'(drop_cnt), 32'd3);

    // drain while pushing, across pointer wrap
    popped.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'(16'h10 + i), 6'b010000, 1);
      step();
    end
    check("pop_order_n", 32'(popped.size()), 32'd8);
    for (int i = 0; i < 4; i++) check("pop_order_lit", 32'(popped[i]), 32'(i + 1));

    // drain, then steady state of two with push+pop each cycle
    drive(0, 16'h0, 6'h0, 1);
    for (int i = 0; i < 5; i++) step();
    drive(1, 16'h0A00, 6'b000001, 0); step();
    drive(1, 16'h0A01, 6'b000001, 0); step();
    popped.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'(16'h0B00 + i), 6'b000010, 1);
      step();
    end
    check("steady_count_lit", 32'(count), 32'd2);
    check("steady_first_lit", 32'(popped[0]), 32'h0A00);
    check("steady_third_lit", 32'(popped[2]), 32'h0B00);

    // flag classes
    drive(0, 16'h0, 6'h0, 1);
    for (int i = 0; i < 3; i++) step();
    drive(1, 16'hFF80, 6'b001001, 0); step();
    check("mul_flags_lit", 32'(out_flags), 32'b0100);
    drive(0, 16'h0, 6'h0, 1); step();
    drive(1, 16'h0000, 6'b100000, 0); step();
    check("cmp_flags_lit", 32'(out_flags), 32'b1000);
    drive(1, 16'h0001, 6'b100000, 1); step();
    check("cmp_flags1_lit", 32'(out_flags), 32'b0000);
    drive(1, 16'h0000, 6'b111000, 1); step();
    check("other_flags_lit", 32'(out_flags), 32'b0000);
    drive(0, 16'h0, 6'h0, 1); step();

    // drop counter saturation
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'(i), 6'b000000, 0);
      step();
    end
    drive(1, 16'h7777, 6'b000000, 0);
    for (int i = 0; i < 260; i++) step();
    check("drop_sat_lit", 32'(drop_cnt), 32'd255);

    // reset while pushing discards everything
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 16'h0, 6'h0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'(16'h0C00 + i), 6'b011000, 0);
      step();
    end
    rst = 1'b1;
    drive(1, 16'h0CFF, 6'b011000, 0);
    step();
    rst = 1'b0;
    check("rst_count_lit", 32'(count), 32'd0);
    check("rst_valid_lit", 32'(out_valid), 32'd0);
    check("rst_drop_lit", 32'(drop_cnt), 32'd0);
    drive(0, 16'h0, 6'h0, 1);
    step();
    check("rst_idle_valid_lit", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
